// File: rtl/alu_pkg.sv
// Shared constants for the ALU execute stage: widths, din field layout,
// opcode encodings and FSM state encoding.
package alu_pkg;

   localparam int ALU_WIDTH = 10;
   localparam int ALU_OPW   = 3;
   localparam int SHAMT_W   = 4;
   localparam int DIN_W     = 2 * ALU_WIDTH + ALU_OPW;

   localparam int DIN_OP_LSB = 0;
   localparam int DIN_B_LSB  = DIN_OP_LSB + ALU_OPW;
   localparam int DIN_A_LSB  = DIN_B_LSB + ALU_WIDTH;

   localparam logic [ALU_OPW-1:0] OP_ADD   = 3'b000;
   localparam logic [ALU_OPW-1:0] OP_SUB   = 3'b001;
   localparam logic [ALU_OPW-1:0] OP_AND   = 3'b010;
   localparam logic [ALU_OPW-1:0] OP_OR    = 3'b011;
   localparam logic [ALU_OPW-1:0] OP_XOR   = 3'b100;
   localparam logic [ALU_OPW-1:0] OP_SLL   = 3'b101;
   localparam logic [ALU_OPW-1:0] OP_MUL   = 3'b110;
   localparam logic [ALU_OPW-1:0] OP_PASSB = 3'b111;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } state_t;

endpackage

// File: rtl/mul_seq10.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
// product presents the final value combinationally during the done cycle.
module mul_seq10 #(
   parameter int WIDTH = 10,
   parameter int CNT_W = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 abort,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

   logic [2*WIDTH-1:0] mcand_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [2*WIDTH-1:0] addend;
   logic [2*WIDTH-1:0] acc_sum;
   logic [WIDTH-1:0]   mplier_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               busy_reg;

   assign addend  = mplier_reg[0] ? mcand_reg : '0;
   assign acc_sum = acc_reg + addend;
   assign done    = busy_reg && (count_reg == LAST);
   assign busy    = busy_reg;
   assign product = acc_sum;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mcand_reg  <= '0;
         acc_reg    <= '0;
         mplier_reg <= '0;
         count_reg  <= '0;
         busy_reg   <= 1'b0;
      end else if (abort) begin
         busy_reg  <= 1'b0;
         count_reg <= '0;
      end else if (start) begin
         mcand_reg  <= {{WIDTH{1'b0}}, a};
         mplier_reg <= b;
         acc_reg    <= '0;
         count_reg  <= '0;
         busy_reg   <= 1'b1;
      end else if (busy_reg) begin
         acc_reg    <= acc_sum;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         if (done) begin
            busy_reg  <= 1'b0;
            count_reg <= '0;
         end else begin
            count_reg <= count_reg + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/alu_execute_stage.sv
// Single-issue ALU execute stage: one-cycle ALU ops, multi-cycle MUL that
// stalls upstream while the sequential multiplier runs.
module alu_execute_stage
   import alu_pkg::*;
#(
   parameter int WIDTH = ALU_WIDTH,
   parameter int OPW   = ALU_OPW
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [2*WIDTH+OPW-1:0]    din,
   input  logic                      valid_in,
   input  logic                      flush,
   output logic                      stall,
   output logic [WIDTH-1:0]          result,
   output logic                      zero,
   output logic                      carry,
   output logic                      valid_out
);

   localparam int B_LSB = DIN_OP_LSB + OPW;
   localparam int A_LSB = B_LSB + WIDTH;

   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [OPW-1:0]     opcode;

   state_t             state_reg;
   state_t             state_next;
   logic [WIDTH-1:0]   result_reg;
   logic [WIDTH-1:0]   result_next;
   logic               carry_reg;
   logic               carry_next;
   logic               valid_reg;
   logic               valid_next;

   logic [WIDTH-1:0]   alu_res;
   logic               alu_carry;
   logic [WIDTH:0]     sum;
   logic [SHAMT_W-1:0] shamt;
   logic [2*WIDTH-1:0] shifted;

   logic               mul_start;
   logic               mul_busy;
   logic               mul_done;
   logic [2*WIDTH-1:0] mul_product;

   assign op_a   = din[A_LSB +: WIDTH];
   assign op_b   = din[B_LSB +: WIDTH];
   assign opcode = din[DIN_OP_LSB +: OPW];

   assign sum     = {1'b0, op_a} + {1'b0, op_b};
   assign shamt   = op_b[SHAMT_W-1:0];
   assign shifted = {{WIDTH{1'b0}}, op_a} << shamt;

   always_comb begin
      alu_res   = '0;
      alu_carry = 1'b0;
      case (opcode)
         OP_ADD: begin
            alu_res   = sum[WIDTH-1:0];
            alu_carry = sum[WIDTH];
         end
         OP_SUB: begin
            alu_res   = op_a - op_b;
            alu_carry = (op_a < op_b);
         end
         OP_AND:   alu_res = op_a & op_b;
         OP_OR:    alu_res = op_a | op_b;
         OP_XOR:   alu_res = op_a ^ op_b;
         OP_SLL: begin
            // Shifts of WIDTH or more leave result and carry at zero.
            if (int'(shamt) < WIDTH) begin
               alu_res   = shifted[WIDTH-1:0];
               alu_carry = |shifted[2*WIDTH-1:WIDTH];
            end
         end
         OP_PASSB: alu_res = op_b;
         default: ;
      endcase
   end

   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      carry_next  = carry_reg;
      valid_next  = 1'b0;
      mul_start   = 1'b0;
      if (flush) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE: begin
               if (valid_in) begin
                  if (opcode == OP_MUL) begin
                     mul_start  = 1'b1;
                     state_next = MUL_BUSY;
                  end else begin
                     result_next = alu_res;
                     carry_next  = alu_carry;
                     valid_next  = 1'b1;
                  end
               end
            end
            MUL_BUSY: begin
               if (mul_done) begin
                  state_next  = IDLE;
                  result_next = mul_product[WIDTH-1:0];
                  carry_next  = |mul_product[2*WIDTH-1:WIDTH];
                  valid_next  = 1'b1;
               end else if (!mul_busy) begin
                  state_next = IDLE;
               end
            end
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg  <= IDLE;
         result_reg <= '0;
         carry_reg  <= 1'b0;
         valid_reg  <= 1'b0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         carry_reg  <= carry_next;
         valid_reg  <= valid_next;
      end
   end

   mul_seq10 #(
      .WIDTH (WIDTH),
      .CNT_W (SHAMT_W)
   ) u_mul (
      .clk     (clk),
      .reset   (reset),
      .start   (mul_start),
      .abort   (flush),
      .a       (op_a),
      .b       (op_b),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   assign stall     = (state_reg == MUL_BUSY);
   assign result    = result_reg;
   assign zero      = (result_reg == '0);
   assign carry     = carry_reg;
   assign valid_out = valid_reg;

endmodule

// File: doc/alu_execute_stage.md
ALU_EXECUTE_STAGE -- requirements
Module: alu_execute_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 10, operand/result width.
REQ-002 SHALL have parameter OPW, default 3, opcode width.
REQ-003 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port din, input, 23, upstream pipeline-register word: [22:13] operand A, [12:3] operand B, [2:0] opcode.
REQ-006 SHALL have port valid_in, input, 1, din holds an instruction this cycle.
REQ-007 SHALL have port flush, input, 1, synchronous abort of the in-flight operation.
REQ-008 SHALL have port stall, output, 1, drives upstream register en low (upstream en = ~stall).
REQ-009 SHALL have port result, output, 10, registered result.
REQ-010 SHALL have port zero, output, 1, result == 0.
REQ-011 SHALL have port carry, output, 1, carry/borrow/overflow flag.
REQ-012 SHALL have port valid_out, output, 1, one-cycle strobe marking new result/flags.

Function
REQ-013 Opcodes SHALL be: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL (A << B[3:0]), 110 MUL, 111 PASSB.
REQ-014 FSM states SHALL be IDLE and MUL_BUSY only.
REQ-015 In IDLE with valid_in=1 and non-MUL opcode, result/flags SHALL register on that edge; valid_out=1 the next cycle (latency 1).
REQ-016 ADD SHALL set carry = bit 10 of the 11-bit sum; SUB SHALL set carry = 1 when A < B (borrow); result is the low 10 bits, wrap-around.
REQ-017 AND/OR/XOR/PASSB SHALL clear carry.
REQ-018 SLL with B[3:0] >= 10 SHALL give result 0, carry 0; otherwise carry = OR of bits shifted out.
REQ-019 In IDLE with valid_in=1 and opcode MUL, the FSM SHALL enter MUL_BUSY and latch A and B.
REQ-020 MUL SHALL use shift-add, one multiplier bit per cycle, exactly 10 cycles in MUL_BUSY; result = low 10 bits of product; carry = 1 if any of product bits [19:10] are nonzero.
REQ-021 stall SHALL be 1 exactly while state == MUL_BUSY (combinational from state); valid_out SHALL strobe the cycle after the last iteration, coinciding with return to IDLE and stall=0.
REQ-022 valid_in SHALL be ignored while in MUL_BUSY.
REQ-023 With valid_in=0 in IDLE, valid_out SHALL be 0 and result/zero/carry SHALL hold their previous values.
REQ-024 flush=1 SHALL return the FSM to IDLE on the next edge, suppress valid_out, and discard any instruction presented that cycle; result/flags hold.
REQ-025 zero SHALL always equal (result == 0) for the registered result.

Reset
REQ-026 reset=0 SHALL asynchronously force state IDLE, result 0, zero 1, carry 0, valid_out 0, stall 0, and clear the iteration counter and multiplier registers.
REQ-027 reset asserted mid-MUL SHALL abort the multiply with no valid_out after release.

Structure
REQ-028 A shared package alu_pkg SHALL hold WIDTH, OPW, opcode constants, din field bit positions and the FSM state encoding.
REQ-029 The multiplier SHALL be a sub-module mul_seq10 (start, busy, done, 20-bit product, 4-bit iteration counter); the ALU ops and FSM stay in alu_execute_stage.

Verification
REQ-030 ADD A=0x3FF, B=0x001 -> next cycle result=0, zero=1, carry=1, valid_out=1.
REQ-031 MUL A=25, B=20 -> stall=1 for 10 cycles, then result=500, carry=0, valid_out=1 with stall=0.
REQ-032 MUL A=40, B=40 -> result=576, carry=1 after 10 busy cycles.
REQ-033 SUB A=5, B=7 -> result=0x3FE, carry=1; SLL A=1, B=12 -> result=0, zero=1, carry=0.
REQ-034 Back-to-back ADD, MUL, ADD with valid_in held -> exactly three valid_out strobes in order; the second ADD is accepted only after stall drops.
REQ-035 reset=0 at busy cycle 5 of a MUL (and separately flush=1 at busy cycle 5) -> stall=0, no valid_out strobe, next ADD completes normally with latency 1.
